// File: rtl/count_pkg.sv
// Shared types for the count capture unit.
// Edge-select encodings and the default count width.
package count_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    CAP_OFF  = 2'd0,
    CAP_RISE = 2'd1,
    CAP_FALL = 2'd2,
    CAP_BOTH = 2'd3
  } cap_mode_e;

  function automatic logic edge_ok(
    input cap_mode_e m,
    input logic      rise,
    input logic      fall
  );
    logic ok;
    ok = 1'b0;
    unique case (m)
      CAP_OFF:  ok = 1'b0;
      CAP_RISE: ok = rise;
      CAP_FALL: ok = fall;
      CAP_BOTH: ok = rise | fall;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/count_capture_unit_if.sv
// Read port of the capture FIFO.
// master = the unit, slave = the host side.
interface count_capture_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_ready_i;
  logic [LW-1:0]    level_o;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    output level_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    input  level_o,
    output rd_ready_i
  );

endinterface

// File: rtl/capture_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers.
// A pop frees a slot for a same-cycle push when full.
module capture_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                   (wr_q[AW] != rd_q[AW]);

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state pointers.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + LW'(1);
    if (do_pop)  rd_d = rd_q + LW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign level_o = wr_q - rd_q;

endmodule

// File: rtl/count_capture_unit.sv
// Timestamps async events with the count bus into a FIFO
// and pulses match_o on entry into count == cmp_val.
module count_capture_unit
  import count_pkg::*;
#(
  parameter int WIDTH       = COUNT_WIDTH,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     count_i,
  input  logic                 count_vld_i,
  input  logic                 cap_in,
  input  logic [1:0]           cap_mode_i,
  input  logic                 cmp_en_i,
  input  logic [WIDTH-1:0]     cmp_val_i,
  output logic                 match_o,
  output logic                 miss_o,
  input  logic                 miss_clr_i,
  count_capture_unit_if.master rd
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   eq_q;
  logic                   match_q, match_d;
  logic                   miss_q, miss_d;

  logic s_cap;
  logic rise;
  logic fall;
  logic evt;
  logic eq;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic miss_set;
  logic [WIDTH-1:0] head;
  logic [LW-1:0]    level;

  // Metastability synchronizer plus edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_cap = sync_q[SYNC_STAGES-1];
  assign rise  = s_cap & ~hist_q;
  assign fall  = ~s_cap & hist_q;
  assign evt   = edge_ok(cap_mode_e'(cap_mode_i), rise, fall);

  assign pop      = rd.rd_ready_i & ~empty;
  assign push     = evt & count_vld_i & (~full | pop);
  assign miss_set = evt & (~count_vld_i | (full & ~pop));

  assign eq = cmp_en_i & count_vld_i & (count_i == cmp_val_i);

  // Next state for the sticky miss flag and match pulse.
  always_comb begin
    miss_d  = miss_set | (miss_q & ~miss_clr_i);
    match_d = eq & ~eq_q;
  end

  // Compare history, match pulse and miss flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eq_q    <= 1'b0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      eq_q    <= eq;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (count_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign match_o       = match_q;
  assign miss_o        = miss_q;
  assign rd.rd_valid_o = ~empty;
  assign rd.rd_data_o  = head;
  assign rd.level_o    = level;

endmodule

// File: tb/tb_count_capture_unit.sv
// Bench for count_capture_unit: directed scenarios then
// random stimulus, all checked against a queue-based model.
module tb_count_capture_unit;
  import count_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int S  = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] cnt = '0;
  logic         vld = 1'b0;
  logic         cap = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         en = 1'b0;
  logic [W-1:0] cval = '0;
  logic         match;
  logic         miss;
  logic         clr = 1'b0;

  count_capture_unit_if #(.WIDTH(W), .DEPTH(D)) rd_if ();

  count_capture_unit #(
    .WIDTH       (W),
    .DEPTH       (D),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .count_i     (cnt),
    .count_vld_i (vld),
    .cap_in      (cap),
    .cap_mode_i  (mode),
    .cmp_en_i    (en),
    .cmp_val_i   (cval),
    .match_o     (match),
    .miss_o      (miss),
    .miss_clr_i  (clr),
    .rd          (rd_if.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit       capq[$];
  bit [W-1:0] mq[$];
  bit       m_miss;
  bit       m_match;
  bit       m_eqp;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    capq.delete();
    for (int i = 0; i <= S; i++) capq.push_back(1'b0);
    mq.delete();
    m_miss  = 1'b0;
    m_match = 1'b0;
    m_eqp   = 1'b0;
  endtask

  // An event on cap_in becomes visible S samples later;
  // capq[0] is the older, capq[1] the newer of that pair.
  task automatic model_tick();
    bit now_v, old_v, ev, pop, push, set, eq;
    now_v = capq[1];
    old_v = capq[0];
    ev = 1'b0;
    case (mode)
      CAP_RISE: ev = now_v && !old_v;
      CAP_FALL: ev = !now_v && old_v;
      CAP_BOTH: ev = now_v != old_v;
      default:  ev = 1'b0;
    endcase
    pop  = rd_if.rd_ready_i && (mq.size() != 0);
    push = 1'b0;
    set  = 1'b0;
    if (ev) begin
      if (!vld) set = 1'b1;
      else if (mq.size() == D && !pop) set = 1'b1;
      else push = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(cnt);
    m_miss = set || (m_miss && !clr);
    eq = en && vld && (cnt == cval);
    m_match = eq && !m_eqp;
    m_eqp = eq;
    capq.push_back(cap);
    void'(capq.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    chk("valid", 32'(rd_if.rd_valid_o), 32'(mq.size() != 0));
    chk("level", 32'(rd_if.level_o), 32'(mq.size()));
    if (mq.size() != 0)
      chk("data", 32'(rd_if.rd_data_o), 32'(mq[0]));
    chk("match", 32'(match), 32'(m_match));
    chk("miss", 32'(miss), 32'(m_miss));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // one capture edge with the count held over the detect cycle
  task automatic pulse(input logic [W-1:0] v);
    cnt = v;
    cap = 1'b1;
    cyc(2);
    cap = 1'b0;
    cyc(2);
  endtask

  initial begin
    rd_if.rd_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_if.rd_valid_o), 32'd0);
    chk("rst_level", 32'(rd_if.level_o), 32'd0);
    chk("rst_data", 32'(rd_if.rd_data_o), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    model_reset();
    reset_n = 1'b1;

    // single rising capture of 0x10, then pop
    mode = CAP_RISE;
    vld  = 1'b1;
    cnt  = 8'h10;
    cap  = 1'b1;
    cyc(1);
    cap = 1'b0;
    cyc(4);
    rd_if.rd_ready_i = 1'b1;
    cyc(2);
    rd_if.rd_ready_i = 1'b0;

    // both edges 5 cycles apart, then mode off
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? CAP_BOTH : CAP_OFF;
      for (int i = 0; i < 12; i++) begin
        cnt = 8'h20 + 8'(i);
        if (i == 0) cap = 1'b1;
        if (i == 5) cap = 1'b0;
        step();
      end
    end
    rd_if.rd_ready_i = 1'b1;
    cyc(3);
    rd_if.rd_ready_i = 1'b0;

    // fill, overflow, drain
    mode = CAP_RISE;
    for (int k = 0; k < 5; k++) pulse(8'hA0 + 8'(k));
    rd_if.rd_ready_i = 1'b1;
    cyc(5);
    rd_if.rd_ready_i = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;

    // full FIFO with a pop coinciding with the push
    for (int k = 0; k < 4; k++) pulse(8'hB0 + 8'(k));
    cnt = 8'hC5;
    cap = 1'b1;
    cyc(2);
    rd_if.rd_ready_i = 1'b1;
    cyc(1);
    rd_if.rd_ready_i = 1'b0;
    cap = 1'b0;
    cyc(2);
    rd_if.rd_ready_i = 1'b1;
    cyc(5);
    rd_if.rd_ready_i = 1'b0;

    // capture with bus not driven, clear, clear+set
    vld = 1'b0;
    pulse(8'h33);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cap = 1'b1;
    cyc(2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cap = 1'b0;
    cyc(2);
    vld = 1'b1;

    // compare: stall on match value, then disabled
    cval = 8'h7F;
    for (int m = 0; m < 2; m++) begin
      en = (m == 0);
      for (int i = 0; i < 5; i++) begin
        cnt = (i == 0) ? 8'h7E : (i == 4) ? 8'h80 : 8'h7F;
        step();
      end
    end
    en   = 1'b1;
    cnt  = 8'h30;
    cval = 8'h31;
    cyc(2);
    cval = 8'h30;
    cyc(2);
    en = 1'b0;

    // async reset with three entries queued
    pulse(8'h61);
    pulse(8'h62);
    pulse(8'h63);
    en   = 1'b1;
    cval = 8'h63;
    cnt  = 8'h62;
    cyc(1);
    cnt = 8'h63;
    cap = 1'b1;
    vld = 1'b0;
    cyc(3);
    vld = 1'b1;
    chk("pre_rst_level", 32'(rd_if.level_o), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rd_if.rd_valid_o), 32'd0);
    chk("arst_level", 32'(rd_if.level_o), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_miss", 32'(miss), 32'd0);
    model_reset();
    en  = 1'b0;
    cap = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulse(8'h55);
    rd_if.rd_ready_i = 1'b1;
    cyc(2);
    rd_if.rd_ready_i = 1'b0;

    // random phase
    mode = CAP_BOTH;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cap = ~cap;
      if ($urandom_range(0, 99) == 0)
        mode = 2'($urandom_range(0, 3));
      vld = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 4))
        0, 1: cnt = cnt + 8'd1;
        2:    cnt = cnt - 8'd1;
        3:    cnt = cnt;
        default: cnt = 8'($urandom);
      endcase
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0)
        cval = cnt + 8'($urandom_range(0, 2));
      rd_if.rd_ready_i = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
